dds_multi_core: RTL

- Parametrised successor of the single-pair DDS output stage.
- NUM_CH independent channels, each with a 32-bit phase accumulator, phase offset and amplitude scaling.
- Per-channel mode: off, direct, one-shot linear frequency sweep, or triangle frequency sweep.
- Configured through a shadow register file with an atomic commit, so all channels update phase-coherently; drives packed offset-binary DAC words.

---
 rtl/dds_pkg.sv | 28 ++
 rtl/dds_sincos_lut.sv | 59 +++++
 rtl/dds_multi_core.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the multi-channel DDS: mode and config-address
// encodings, pipeline latency and the offset-binary midscale helper.
package dds_pkg;

  typedef enum logic [2:0] {
    MODE_OFF    = 3'd0,
    MODE_DIRECT = 3'd1,
    MODE_SWEEP  = 3'd2,
    MODE_TRI    = 3'd3
  } mode_e;

  typedef enum logic [2:0] {
    ADDR_MODE        = 3'd0,
    ADDR_FWORD       = 3'd1,
    ADDR_PWORD       = 3'd2,
    ADDR_AMP         = 3'd3,
    ADDR_SWEEP_END   = 3'd4,
    ADDR_SWEEP_STEP  = 3'd5,
    ADDR_SWEEP_DWELL = 3'd6
  } cfg_addr_e;

  localparam int unsigned LATENCY = 4;

  function automatic logic [31:0] midscale(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/dds_sincos_lut.sv
// Full-wave sine lookup built from a quarter-wave table with symmetry folding;
// one registered output stage.
module dds_sincos_lut #(
  parameter int unsigned LUT_AW    = 10,
  parameter int unsigned DAC_WIDTH = 14
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [LUT_AW-1:0]           addr,
  output logic signed [DAC_WIDTH-1:0] sample
);

  localparam int unsigned QW = LUT_AW - 2;
  localparam int unsigned QN = 1 << QW;
  localparam longint PEAK_INT = (longint'(1) << (DAC_WIDTH - 1)) - 1;
  localparam logic [DAC_WIDTH-2:0] PEAK = '1;

  // Taylor series of sin(pi/2 * t) in Q30, t = k/QN in [0,1)
  function automatic longint qsin(input int unsigned k);
    longint t, t2, p, r;
    t  = longint'(k) << (30 - QW);
    t2 = (t * t) >>> 30;
    p  = 64'sd172273;
    p  = -64'sd5026995   + ((p * t2) >>> 30);
    p  = 64'sd85569306   + ((p * t2) >>> 30);
    p  = -64'sd693598668 + ((p * t2) >>> 30);
    p  = 64'sd1686629713 + ((p * t2) >>> 30);
    r  = (((p * t) >>> 30) * PEAK_INT + (longint'(1) << 29)) >>> 30;
    if (r > PEAK_INT) r = PEAK_INT;
    if (r < 0) r = 0;
    return r;
  endfunction

  logic [DAC_WIDTH-2:0] rom [QN];

  for (genvar k = 0; k < QN; k++) begin : g_rom
    assign rom[k] = (DAC_WIDTH-1)'(qsin(k));
  end

  logic [1:0]           quad;
  logic [QW-1:0]        idx;
  logic [QW-1:0]        ridx;
  logic [DAC_WIDTH-2:0] mag;

  // Odd quadrants read the table mirrored; the exact quarter point maps to PEAK
  always_comb begin
    quad = addr[LUT_AW-1:LUT_AW-2];
    idx  = addr[QW-1:0];
    ridx = '0 - idx;
    mag  = rom[idx];
    if (quad[0]) mag = (idx == '0) ? PEAK : rom[ridx];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sample <= '0;
    else       sample <= quad[1] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  end

endmodule

// File: rtl/dds_multi_core.sv
// Multi-channel DDS with shadow/active config, frequency sweeps and a 4-stage
// datapath. Define DDS_PHASE_DITHER_EN to add LFSR phase dither ahead of S1.
module dds_multi_core
  import dds_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned DAC_WIDTH = 14,
  parameter int unsigned LUT_AW    = 10,
  parameter int unsigned AMP_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        cfg_wen,
  input  logic [2:0]                  cfg_ch,
  input  logic [2:0]                  cfg_addr,
  input  logic [31:0]                 cfg_wdata,
  input  logic                        cfg_commit,
  input  logic                        phase_clr,
  output logic [NUM_CH*DAC_WIDTH-1:0] dac_data,
  output logic                        dac_valid,
  output logic [NUM_CH-1:0]           sweep_done,
  output logic [NUM_CH*32-1:0]        cur_fword
);

  localparam int unsigned PW = DAC_WIDTH + AMP_WIDTH + 1;
  localparam logic [DAC_WIDTH-1:0] MID = DAC_WIDTH'(midscale(DAC_WIDTH));

  logic [LATENCY-1:0] vld_sr;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) vld_sr <= '0;
    else       vld_sr <= {vld_sr[LATENCY-2:0], 1'b1};
  end
  assign dac_valid = vld_sr[LATENCY-1];

  logic [31:0] dither;
`ifdef DDS_PHASE_DITHER_EN
  localparam int unsigned DTH_W = ((32 - LUT_AW) > 16) ? 16 : (32 - LUT_AW);
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3]};
  end
  assign dither = 32'(lfsr[DTH_W-1:0]);
`else
  assign dither = '0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic                        wr;
    logic [2:0]                  sh_mode, sh_mode_nx, act_mode;
    logic [31:0]                 sh_fword, sh_fword_nx, sh_pword, sh_pword_nx;
    logic [31:0]                 sh_end, sh_end_nx, sh_step, sh_step_nx, sh_dwell, sh_dwell_nx;
    logic [AMP_WIDTH-1:0]        sh_amp, sh_amp_nx, act_amp;
    logic [31:0]                 act_pword, act_start, act_end, act_step, act_dwell;
    logic [31:0]                 fw, dwell_cnt, acc, ph, tgt;
    logic                        up, to_end, done, mv_up, hit, sweeping, running;
    logic [32:0]                 nxt;
    logic [LUT_AW-1:0]           s1_addr;
    logic signed [DAC_WIDTH-1:0] s2_smp, s3_smp;
    logic signed [PW-1:0]        a_ext, b_ext, prod;
    logic                        s1_on, s2_on, s3_on;
    logic [DAC_WIDTH-1:0]        dac_q;

    assign wr = cfg_wen && (cfg_ch == 3'(i));

    // Next-shadow values let a same-cycle write be seen by the commit
    always_comb begin
      sh_mode_nx  = sh_mode;
      sh_fword_nx = sh_fword;
      sh_pword_nx = sh_pword;
      sh_amp_nx   = sh_amp;
      sh_end_nx   = sh_end;
      sh_step_nx  = sh_step;
      sh_dwell_nx = sh_dwell;
      if (wr) begin
        case (cfg_addr)
          ADDR_MODE:        sh_mode_nx  = cfg_wdata[2:0];
          ADDR_FWORD:       sh_fword_nx = cfg_wdata;
          ADDR_PWORD:       sh_pword_nx = cfg_wdata;
          ADDR_AMP:         sh_amp_nx   = cfg_wdata[AMP_WIDTH-1:0];
          ADDR_SWEEP_END:   sh_end_nx   = cfg_wdata;
          ADDR_SWEEP_STEP:  sh_step_nx  = cfg_wdata;
          ADDR_SWEEP_DWELL: sh_dwell_nx = cfg_wdata;
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        sh_mode <= '0; sh_fword <= '0; sh_pword <= '0; sh_amp <= '0;
        sh_end  <= '0; sh_step  <= '0; sh_dwell <= '0;
      end else begin
        sh_mode <= sh_mode_nx; sh_fword <= sh_fword_nx; sh_pword <= sh_pword_nx;
        sh_amp  <= sh_amp_nx;  sh_end   <= sh_end_nx;   sh_step  <= sh_step_nx;
        sh_dwell <= sh_dwell_nx;
      end
    end

    assign sweeping = (act_mode == MODE_SWEEP) || (act_mode == MODE_TRI);
    assign running  = (act_mode == MODE_DIRECT) || sweeping;

    // 33-bit step toward the current target; a borrow on the way down counts as passing it
    always_comb begin
      tgt   = to_end ? act_end : act_start;
      mv_up = to_end ? up : !up;
      nxt   = mv_up ? ({1'b0, fw} + {1'b0, act_step}) : ({1'b0, fw} - {1'b0, act_step});
      hit   = mv_up ? (nxt >= {1'b0, tgt}) : (nxt[32] || (nxt <= {1'b0, tgt}));
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        act_mode <= '0; act_amp <= '0; act_pword <= '0; act_start <= '0;
        act_end <= '0; act_step <= '0; act_dwell <= '0;
        fw <= '0; dwell_cnt <= '0; up <= 1'b0; to_end <= 1'b0; done <= 1'b0;
      end else if (cfg_commit) begin
        act_mode  <= sh_mode_nx;  act_amp  <= sh_amp_nx;  act_pword <= sh_pword_nx;
        act_start <= sh_fword_nx; act_end  <= sh_end_nx;  act_step  <= sh_step_nx;
        act_dwell <= sh_dwell_nx; fw       <= sh_fword_nx;
        dwell_cnt <= '0;
        up        <= (sh_end_nx >= sh_fword_nx);
        to_end    <= 1'b1;
        done      <= 1'b0;
      end else if (sweeping && (act_step != '0) && !done) begin
        if ((act_mode == MODE_SWEEP) && (fw == act_end)) begin
          done <= 1'b1;
        end else if (dwell_cnt == act_dwell) begin
          dwell_cnt <= '0;
          if (hit) begin
            fw <= tgt;
            if (act_mode == MODE_SWEEP) done <= 1'b1;
            else                        to_end <= !to_end;
          end else begin
            fw <= nxt[31:0];
          end
        end else begin
          dwell_cnt <= dwell_cnt + 32'd1;
        end
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)          acc <= '0;
      else if (phase_clr) acc <= '0;
      else if (running)   acc <= acc + fw;
      else                acc <= '0;
    end

    assign ph    = acc + act_pword + dither;
    assign a_ext = PW'(s2_smp);
    assign b_ext = PW'({1'b0, act_amp});
    assign prod  = a_ext * b_ext;

    dds_sincos_lut #(.LUT_AW(LUT_AW), .DAC_WIDTH(DAC_WIDTH)) u_lut (
      .clk    (clk),
      .rstn   (rstn),
      .addr   (s1_addr),
      .sample (s2_smp)
    );

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        s1_addr <= '0; s1_on <= 1'b0; s2_on <= 1'b0;
        s3_smp  <= '0; s3_on <= 1'b0; dac_q <= MID;
      end else begin
        s1_addr <= LUT_AW'(ph >> (32 - LUT_AW));
        s1_on   <= running;
        s2_on   <= s1_on;
        s3_smp  <= DAC_WIDTH'(prod >>> AMP_WIDTH);
        s3_on   <= s2_on;
        dac_q   <= s3_on ? {~s3_smp[DAC_WIDTH-1], s3_smp[DAC_WIDTH-2:0]} : MID;
      end
    end

    assign dac_data[i*DAC_WIDTH +: DAC_WIDTH] = dac_q;
    assign sweep_done[i]                      = done;
    assign cur_fword[i*32 +: 32]              = fw;
  end

endmodule
